// File: rtl/softmax_row_scheduler_pkg.sv
// Shared types and width helpers for the softmax row scheduler.
// Imported by the arbiter and the top.
package softmax_row_scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      STREAM,
      DRAIN
   } state_t;

   function automatic int head_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_w(input int row_len);
      return $clog2(row_len + 1);
   endfunction

endpackage

// File: rtl/softmax_row_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr.
// Reports one-hot grant, its index and whether any request exists.
module softmax_row_scheduler_rr_arbiter
   import softmax_row_scheduler_pkg::*;
#(
   parameter int NUM_HEAD = 8,
   parameter int HW       = head_w(NUM_HEAD)
) (
   input  logic [NUM_HEAD-1:0] req,
   input  logic [HW-1:0]       ptr,
   output logic [NUM_HEAD-1:0] gnt_oh,
   output logic [HW-1:0]       gnt_idx,
   output logic                found
);

   logic [HW-1:0] kk;

   // Scan from farthest to nearest so the nearest hit wins.
   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      found   = 1'b0;
      kk      = '0;
      for (int i = NUM_HEAD - 1; i >= 0; i--) begin
         kk = HW'((int'(ptr) + i) % NUM_HEAD);
         if (req[kk]) begin
            found   = 1'b1;
            gnt_idx = kk;
            gnt_oh  = NUM_HEAD'(1) << kk;
         end
      end
   end

endmodule

// File: rtl/softmax_row_scheduler.sv
// Row-granular scheduler sharing one softmax unit among several heads.
// Streams a row in, routes its results back, and fences LUT writes.
module softmax_row_scheduler
   import softmax_row_scheduler_pkg::*;
#(
   parameter int NUM_HEAD = 8,
   parameter int ROW_LEN  = 256,
   parameter int DATA_W   = 8,
   parameter int LUT_ADDR = 16,
   parameter int LUT_DATA = 16,
   parameter int CNT_W    = cnt_w(ROW_LEN)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [7:0]                 cfg_shift,
   input  logic                       host_lut_wen,
   input  logic [LUT_ADDR-1:0]        host_lut_waddr,
   input  logic [LUT_DATA-1:0]        host_lut_wdata,
   output logic                       host_lut_ready,
   input  logic [NUM_HEAD-1:0]        req_valid,
   input  logic [NUM_HEAD*DATA_W-1:0] req_data,
   output logic [NUM_HEAD-1:0]        req_ready,
   output logic [NUM_HEAD-1:0]        rsp_valid,
   output logic [DATA_W-1:0]          rsp_data,
   output logic [7:0]                 sm_cfg_shift,
   output logic                       sm_lut_wen,
   output logic [LUT_ADDR-1:0]        sm_lut_waddr,
   output logic [LUT_DATA-1:0]        sm_lut_wdata,
   output logic [DATA_W-1:0]          sm_idata,
   output logic                       sm_idata_valid,
   input  logic [DATA_W-1:0]          sm_odata,
   input  logic                       sm_odata_valid,
   output logic                       busy,
   output logic                       err_spurious
);

   localparam int HW = head_w(NUM_HEAD);
   localparam logic [CNT_W-1:0] ROW_END  = CNT_W'(ROW_LEN);
   localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROW_LEN - 1);
   localparam logic [HW-1:0]    HEAD_MAX = HW'(NUM_HEAD - 1);

   state_t state, state_d;

   logic [HW-1:0]       rr_ptr;
   logic [HW-1:0]       grant;
   logic [NUM_HEAD-1:0] grant_oh;
   logic [CNT_W-1:0]    in_cnt, in_cnt_d;
   logic [CNT_W-1:0]    out_cnt, out_cnt_d;
   logic                lut_rdy;

   logic [NUM_HEAD-1:0] arb_oh;
   logic [HW-1:0]       arb_idx;
   logic                arb_found;

   logic                in_acc;
   logic                out_ok;
   logic                spur;
   logic                routing;
   logic [DATA_W-1:0]   cur_data;

   softmax_row_scheduler_rr_arbiter #(
      .NUM_HEAD (NUM_HEAD),
      .HW       (HW)
   ) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr),
      .gnt_oh  (arb_oh),
      .gnt_idx (arb_idx),
      .found   (arb_found)
   );

   assign routing  = (state == STREAM) || (state == DRAIN);
   assign in_acc   = (state == STREAM) && req_valid[grant];
   assign out_ok   = sm_odata_valid && routing && (out_cnt != ROW_END);
   assign spur     = sm_odata_valid && !out_ok;
   assign cur_data = req_data[int'(grant)*DATA_W +: DATA_W];

   assign in_cnt_d  = in_cnt + CNT_W'(in_acc && (in_cnt != ROW_END));
   assign out_cnt_d = out_cnt + CNT_W'(out_ok);

   assign busy           = (state != IDLE);
   assign req_ready      = (state == STREAM) ? grant_oh : '0;
   assign host_lut_ready = lut_rdy;

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:   if (|req_valid) state_d = GRANT;
         GRANT:  state_d = arb_found ? STREAM : IDLE;
         STREAM: if (in_acc && (in_cnt == ROW_LAST)) state_d = DRAIN;
         DRAIN:  if (out_cnt_d == ROW_END) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         lut_rdy        <= 1'b0;
         rr_ptr         <= '0;
         grant          <= '0;
         grant_oh       <= '0;
         in_cnt         <= '0;
         out_cnt        <= '0;
         sm_cfg_shift   <= '0;
         sm_lut_wen     <= 1'b0;
         sm_lut_waddr   <= '0;
         sm_lut_wdata   <= '0;
         sm_idata       <= '0;
         sm_idata_valid <= 1'b0;
         rsp_valid      <= '0;
         rsp_data       <= '0;
         err_spurious   <= 1'b0;
      end else begin
         state <= state_d;
         // Ready tracks the next state so it is low for the whole row.
         lut_rdy      <= (state_d == IDLE);
         sm_lut_wen   <= host_lut_wen && lut_rdy;
         sm_lut_waddr <= host_lut_waddr;
         sm_lut_wdata <= host_lut_wdata;

         if ((state == GRANT) && arb_found) begin
            grant        <= arb_idx;
            grant_oh     <= arb_oh;
            rr_ptr       <= (arb_idx == HEAD_MAX) ? '0 : arb_idx + HW'(1);
            sm_cfg_shift <= cfg_shift;
            in_cnt       <= '0;
            out_cnt      <= '0;
         end else begin
            in_cnt  <= in_cnt_d;
            out_cnt <= out_cnt_d;
         end

         sm_idata_valid <= in_acc;
         if (state == STREAM) sm_idata <= cur_data;

         rsp_valid <= out_ok ? grant_oh : '0;
         if (out_ok) rsp_data <= sm_odata;

         if (spur) err_spurious <= 1'b1;
      end
   end

endmodule
